// File: rtl/sram_controller_if.sv
// MEM-stage side of the data-memory backend: request, address, store data, load result, ready.
// No latency of its own; it only carries signals between MEM and the controller.
// ready low from the controller means the whole pipeline must freeze.
interface sram_controller_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    // MEM stage drives requests and consumes the result
    modport master (
        output wr_en,
        output rd_en,
        output address,
        output write_data,
        input  read_data,
        input  ready
    );

    // Controller consumes requests and returns the result
    modport slave (
        input  wr_en,
        input  rd_en,
        input  address,
        input  write_data,
        output read_data,
        output ready
    );
endinterface

// File: rtl/sram_controller.sv
// Splits each 32-bit MEM access into two halfword cycles on a 16-bit asynchronous SRAM.
// Latency: 2*PHASE_CYCLES+2 cycles from request in IDLE to ready=1 (6 at default).
// Backpressure: ready is low while an access is in flight; the top level turns that into a freeze.
module sram_controller #(
    parameter int unsigned BASE_ADDR    = 1024,
    parameter int unsigned PHASE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    sram_controller_if.slave mem_if,
    inout  wire  [15:0]      SRAM_DQ,
    output logic [17:0]      SRAM_ADDR,
    output logic             SRAM_WE_N,
    output logic             SRAM_UB_N,
    output logic             SRAM_LB_N,
    output logic             SRAM_CE_N,
    output logic             SRAM_OE_N
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_DONE
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(PHASE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        op_wr_q, op_wr_d;
    logic [16:0] word_q, word_d;
    logic [31:0] wdat_q, wdat_d;
    logic [31:0] rdat_q, rdat_d;
    logic [17:0] sram_addr_q, sram_addr_d;
    logic        we_n_q, we_n_d;

    logic        req;
    logic        last_cnt;
    logic [31:0] addr_off;
    logic        unused_addr_bits;
    logic        dq_oe;
    logic [15:0] dq_dat;

    assign req      = mem_if.wr_en | mem_if.rd_en;
    assign last_cnt = (cnt_q == LAST_CNT);

    // Offset from the data base; only the word index is kept, the rest wraps away silently
    assign addr_off         = mem_if.address - 32'(BASE_ADDR);
    assign unused_addr_bits = ^{addr_off[31:19], addr_off[1:0]};

    // State, phase counter and latched transaction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_wr_q     <= 1'b0;
            word_q      <= '0;
            wdat_q      <= '0;
            rdat_q      <= '0;
            sram_addr_q <= '0;
            we_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_wr_q     <= op_wr_d;
            word_q      <= word_d;
            wdat_q      <= wdat_d;
            rdat_q      <= rdat_d;
            sram_addr_q <= sram_addr_d;
            we_n_q      <= we_n_d;
        end
    end

    // Next state: latch the request on IDLE exit, count each phase, sample SRAM on a read phase's last cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        word_d  = word_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                    op_wr_d = mem_if.wr_en;
                    word_d  = addr_off[18:2];
                    wdat_d  = mem_if.write_data;
                end
            end
            ST_LOW: begin
                if (last_cnt) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                    if (!op_wr_q) rdat_d[15:0] = SRAM_DQ;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_HIGH: begin
                if (last_cnt) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    if (!op_wr_q) rdat_d[31:16] = SRAM_DQ;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // SRAM address and write strobe are registered from the next state so they only move on clock edges;
    // the strobe rises on the last cycle of a write phase to give the SRAM data hold time
    always_comb begin
        sram_addr_d = sram_addr_q;
        we_n_d      = 1'b1;
        if (state_d == ST_LOW || state_d == ST_HIGH) begin
            sram_addr_d = {word_d, (state_d == ST_HIGH)};
            we_n_d      = !(op_wr_d && (cnt_d != LAST_CNT));
        end
    end

    // Data bus is driven only during write phases; reset returns to IDLE and releases it immediately
    assign dq_oe   = op_wr_q && (state_q == ST_LOW || state_q == ST_HIGH);
    assign dq_dat  = (state_q == ST_HIGH) ? wdat_q[31:16] : wdat_q[15:0];
    assign SRAM_DQ = dq_oe ? dq_dat : 16'bz;

    assign SRAM_ADDR = sram_addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

    assign mem_if.read_data = rdat_q;
    assign mem_if.ready     = (state_q == ST_DONE) || (state_q == ST_IDLE && !req);
endmodule

// File: tb/tb_sram_controller.sv
`timescale 1ns/1ps
module tb_sram_controller;
    logic        clk = 1'b0;
    logic        rst;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n, sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n;

    logic [15:0] mem [0:262143];
    logic        model_rd;
    logic        probe;
    logic        tb_drv_en;
    logic [15:0] tb_drv_dat;
    int          total;
    int          bad;

    sram_controller_if bus();

    sram_controller #(.BASE_ADDR(1024), .PHASE_CYCLES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_if    (bus),
        .SRAM_DQ   (sram_dq),
        .SRAM_ADDR (sram_addr),
        .SRAM_WE_N (sram_we_n),
        .SRAM_UB_N (sram_ub_n),
        .SRAM_LB_N (sram_lb_n),
        .SRAM_CE_N (sram_ce_n),
        .SRAM_OE_N (sram_oe_n)
    );

    always #5 clk = ~clk;

    // SRAM model: drives stored data during bench-issued reads; probe drives 0 to expose any DUT drive
    always_comb begin
        tb_drv_en  = probe | (model_rd & sram_we_n);
        tb_drv_dat = probe ? 16'h0000 : mem[sram_addr];
    end
    assign sram_dq = tb_drv_en ? tb_drv_dat : 16'bz;

    always @(posedge clk) begin
        if (!sram_we_n) mem[sram_addr] <= sram_dq;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d);
        bus.wr_en      = wr;
        bus.rd_en      = rd;
        bus.address    = a;
        bus.write_data = d;
        #1;
    endtask

    task automatic test_write();
        logic [17:0] ea [4];
        logic [15:0] ed [4];
        logic        ew [4];
        ea = '{18'd0, 18'd0, 18'd1, 18'd1};
        ed = '{16'hBEEF, 16'hBEEF, 16'hDEAD, 16'hDEAD};
        ew = '{1'b0, 1'b1, 1'b0, 1'b1};
        tick(); drive(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
        total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL wr_ready_idle got=%b want=0", bus.ready); end
        total++; if ({sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n} !== 4'b0000) begin bad++; $display("FAIL const_strobes got=%b want=0000", {sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n}); end
        for (int c = 0; c < 4; c++) begin
            tick(); drive(1'b0, 1'b0, 32'h0000_0BAD, 32'hFFFF_FFFF);
            total++; if (sram_addr !== ea[c]) begin bad++; $display("FAIL wr_addr c=%0d got=%h want=%h", c, sram_addr, ea[c]); end
            total++; if (sram_dq !== ed[c]) begin bad++; $display("FAIL wr_dq c=%0d got=%h want=%h", c, sram_dq, ed[c]); end
            total++; if (sram_we_n !== ew[c]) begin bad++; $display("FAIL wr_we_n c=%0d got=%b want=%b", c, sram_we_n, ew[c]); end
            total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL wr_ready c=%0d got=%b want=0", c, bus.ready); end
        end
        tick(); drive(1'b0, 1'b0, 32'h0000_0BAD, 32'hFFFF_FFFF);
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL wr_ready_done got=%b want=1", bus.ready); end
        total++; if (bus.read_data !== 32'h0) begin bad++; $display("FAIL wr_rdata_kept got=%h want=00000000", bus.read_data); end
        probe = 1'b1; #1;
        total++; if (sram_dq !== 16'h0000) begin bad++; $display("FAIL wr_dq_done_z got=%h want=0000", sram_dq); end
        probe = 1'b0;
        total++; if (mem[0] !== 16'hBEEF) begin bad++; $display("FAIL wr_mem0 got=%h want=BEEF", mem[0]); end
        total++; if (mem[1] !== 16'hDEAD) begin bad++; $display("FAIL wr_mem1 got=%h want=DEAD", mem[1]); end
    endtask

    task automatic test_read();
        logic [17:0] ea [4];
        logic [15:0] ed [4];
        ea = '{18'd0, 18'd0, 18'd1, 18'd1};
        ed = '{16'hBEEF, 16'hBEEF, 16'hDEAD, 16'hDEAD};
        model_rd = 1'b1;
        tick(); drive(1'b0, 1'b1, 32'd1024, 32'hFFFF_FFFF);
        total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL rd_ready_idle got=%b want=0", bus.ready); end
        for (int c = 0; c < 4; c++) begin
            tick(); drive(1'b0, 1'b0, 32'h0000_0BAD, 32'hFFFF_FFFF);
            total++; if (sram_addr !== ea[c]) begin bad++; $display("FAIL rd_addr c=%0d got=%h want=%h", c, sram_addr, ea[c]); end
            total++; if (sram_we_n !== 1'b1) begin bad++; $display("FAIL rd_we_n c=%0d got=%b want=1", c, sram_we_n); end
            total++; if (sram_dq !== ed[c]) begin bad++; $display("FAIL rd_dq_bus c=%0d got=%h want=%h", c, sram_dq, ed[c]); end
        end
        tick(); drive(1'b0, 1'b0, 32'h0000_0BAD, 32'hFFFF_FFFF);
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL rd_ready_done got=%b want=1", bus.ready); end
        total++; if (bus.read_data !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got=%h want=DEADBEEF", bus.read_data); end
        model_rd = 1'b0;
    endtask

    task automatic test_alias();
        logic [17:0] ea [4];
        logic        ew [4];
        ea = '{18'd10, 18'd10, 18'd11, 18'd11};
        ew = '{1'b0, 1'b1, 1'b0, 1'b1};
        // both enables set: must behave as a write
        tick(); drive(1'b1, 1'b1, 32'd1044, 32'hCAFE1234);
        for (int c = 0; c < 4; c++) begin
            tick(); drive(1'b0, 1'b0, 32'h0000_0BAD, 32'h0);
            total++; if (sram_addr !== ea[c]) begin bad++; $display("FAIL both_addr c=%0d got=%h want=%h", c, sram_addr, ea[c]); end
            total++; if (sram_we_n !== ew[c]) begin bad++; $display("FAIL both_we_n c=%0d got=%b want=%b", c, sram_we_n, ew[c]); end
        end
        tick(); drive(1'b0, 1'b0, 32'h0000_0BAD, 32'h0);
        total++; if (bus.read_data !== 32'hDEADBEEF) begin bad++; $display("FAIL both_rdata_kept got=%h want=DEADBEEF", bus.read_data); end
        total++; if ({mem[11], mem[10]} !== 32'hCAFE1234) begin bad++; $display("FAIL both_mem got=%h want=CAFE1234", {mem[11], mem[10]}); end
        // low address bits ignored
        model_rd = 1'b1;
        tick(); drive(1'b0, 1'b1, 32'd1047, 32'hFFFF_FFFF);
        for (int c = 0; c < 4; c++) begin
            tick(); drive(1'b0, 1'b0, 32'h0000_0BAD, 32'hFFFF_FFFF);
            total++; if (sram_addr !== ea[c]) begin bad++; $display("FAIL alias_addr c=%0d got=%h want=%h", c, sram_addr, ea[c]); end
        end
        tick(); drive(1'b0, 1'b0, 32'h0000_0BAD, 32'hFFFF_FFFF);
        total++; if (bus.read_data !== 32'hCAFE1234) begin bad++; $display("FAIL alias_rdata got=%h want=CAFE1234", bus.read_data); end
        model_rd = 1'b0;
        // below base wraps to the top of the SRAM
        ea = '{18'h3FFFE, 18'h3FFFE, 18'h3FFFF, 18'h3FFFF};
        tick(); drive(1'b1, 1'b0, 32'd1020, 32'h55AA33CC);
        for (int c = 0; c < 4; c++) begin
            tick(); drive(1'b0, 1'b0, 32'h0000_0BAD, 32'h0);
            total++; if (sram_addr !== ea[c]) begin bad++; $display("FAIL wrap_addr c=%0d got=%h want=%h", c, sram_addr, ea[c]); end
        end
        tick(); drive(1'b0, 1'b0, 32'h0000_0BAD, 32'h0);
        total++; if ({mem[18'h3FFFF], mem[18'h3FFFE]} !== 32'h55AA33CC) begin bad++; $display("FAIL wrap_mem got=%h want=55AA33CC", {mem[18'h3FFFF], mem[18'h3FFFE]}); end
    endtask

    task automatic test_reset();
        tick(); drive(1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b0; #1;
        total++; if (bus.read_data !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h want=00000000", bus.read_data); end
        total++; if (sram_we_n !== 1'b1) begin bad++; $display("FAIL rst_we_n got=%b want=1", sram_we_n); end
        total++; if (sram_addr !== 18'd0) begin bad++; $display("FAIL rst_addr got=%h want=0", sram_addr); end
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", bus.ready); end
        probe = 1'b1; #1;
        total++; if (sram_dq !== 16'h0000) begin bad++; $display("FAIL rst_dq_z got=%h want=0000", sram_dq); end
        probe = 1'b0;
        tick(); tick();
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick(); #1;
            total++; if (bus.ready !== 1'b1 || sram_we_n !== 1'b1) begin bad++; $display("FAIL idle_ready c=%0d got ready=%b we_n=%b want 1,1", c, bus.ready, sram_we_n); end
        end
    endtask

    task automatic test_back_to_back();
        tick(); drive(1'b1, 1'b0, 32'd1028, 32'h0BADF00D);
        for (int c = 0; c < 4; c++) begin
            tick(); drive(1'b0, 1'b0, 32'h0, 32'h0);
        end
        tick(); drive(1'b0, 1'b0, 32'h0, 32'h0);
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL b2b_done1 got=%b want=1", bus.ready); end
        model_rd = 1'b1;
        tick(); drive(1'b0, 1'b1, 32'd1028, 32'hFFFF_FFFF);
        total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL b2b_idle_ready got=%b want=0", bus.ready); end
        tick(); drive(1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF);
        total++; if (sram_addr !== 18'd2 || sram_we_n !== 1'b1) begin bad++; $display("FAIL b2b_low_start got addr=%h we_n=%b want 2,1", sram_addr, sram_we_n); end
        for (int c = 0; c < 3; c++) begin
            tick(); drive(1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF);
        end
        tick(); drive(1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF);
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL b2b_done2 got=%b want=1", bus.ready); end
        total++; if (bus.read_data !== 32'h0BADF00D) begin bad++; $display("FAIL b2b_rdata got=%h want=0BADF00D", bus.read_data); end
        model_rd = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        logic [15:0] prev19;
        prev19 = mem[19];
        tick(); drive(1'b1, 1'b0, 32'd1060, 32'h9ABC5678);
        for (int c = 0; c < 3; c++) begin
            tick(); drive(1'b0, 1'b0, 32'h0, 32'h0);
        end
        total++; if (sram_we_n !== 1'b0 || sram_dq !== 16'h9ABC) begin bad++; $display("FAIL mid_high_phase got we_n=%b dq=%h want 0,9ABC", sram_we_n, sram_dq); end
        rst = 1'b0; #1;
        total++; if (sram_we_n !== 1'b1) begin bad++; $display("FAIL mid_rst_we_n got=%b want=1", sram_we_n); end
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready got=%b want=1", bus.ready); end
        probe = 1'b1; #1;
        total++; if (sram_dq !== 16'h0000) begin bad++; $display("FAIL mid_rst_dq_z got=%h want=0000", sram_dq); end
        probe = 1'b0;
        tick(); tick();
        rst = 1'b1;
        total++; if (mem[18] !== 16'h5678) begin bad++; $display("FAIL mid_mem18 got=%h want=5678", mem[18]); end
        total++; if (mem[19] !== prev19) begin bad++; $display("FAIL mid_mem19 got=%h want=%h", mem[19], prev19); end
        model_rd = 1'b1;
        tick(); drive(1'b0, 1'b1, 32'd1060, 32'hFFFF_FFFF);
        for (int c = 0; c < 4; c++) begin
            tick(); drive(1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF);
        end
        total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL mid_after_c5 got=%b want=0", bus.ready); end
        tick(); drive(1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF);
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL mid_after_c6 got=%b want=1", bus.ready); end
        total++; if (bus.read_data !== {prev19, 16'h5678}) begin bad++; $display("FAIL mid_after_rdata got=%h want=%h", bus.read_data, {prev19, 16'h5678}); end
        model_rd = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b0;
        probe = 1'b0;
        model_rd = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.address = 32'h0;
        bus.write_data = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        test_write();
        test_read();
        test_alias();
        test_reset();
        test_back_to_back();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sram_controller.md
# sram_controller

Data-memory backend for the ARM pipeline. Sits directly downstream of the MEM stage: it takes MEM's read/write enables, ALU-computed address and store value (val_rm), and performs each 32-bit access on an external 16-bit asynchronous SRAM as two halfword cycles. It returns read data to MEM and drives a ready signal that the top level inverts into a pipeline-wide freeze while an access is in flight.

## Interface
- BASE_ADDR, 1024: first data address; it maps to SRAM halfword 0.
- PHASE_CYCLES, 2: cycles each halfword phase is held. Legal range 2..15.

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  one clock; reset is asynchronous and active-low
- wr_en  in  1  MEM-stage store request
- rd_en  in  1  MEM-stage load request
- address  in  32  byte address from ALU result
- write_data  in  32  store value (val_rm)
- read_data  out  32  registered load result
- ready  out  1  combinational; 0 means freeze the pipeline
- SRAM_DQ  inout  16  SRAM data bus
- SRAM_ADDR  out  18  SRAM halfword address, registered
- SRAM_WE_N  out  1  write strobe, registered, active-low
- SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  out  1 each  constant 0

## Operation
- Word address: w = (address − BASE_ADDR)[18:2], modulo 2^32. Bits [1:0] are ignored. Out-of-range addresses wrap silently and raise no error.
- Low phase uses SRAM_ADDR = {w,0} and data bits [15:0]. High phase uses {w,1} and bits [31:16].
- FSM states: IDLE, LOW, HIGH, DONE. A 4-bit phase counter runs 0..PHASE_CYCLES−1.
  - IDLE: if wr_en or rd_en, latch the operation (wr_en wins if both are set) and go to LOW with counter 0. Otherwise stay.
  - LOW: at counter = PHASE_CYCLES−1, go to HIGH and clear the counter. Otherwise increment.
  - HIGH: same counting rule, then go to DONE.
  - DONE: go to IDLE unconditionally after one cycle.
- Address, operation and write data are latched at IDLE exit. Later changes to the inputs do not affect the transaction in flight.
- A request dropped mid-transaction is still completed.
- ready = 1 in DONE, and in IDLE when there is no request. ready = 0 in all other cases.
- Write: SRAM_DQ carries the selected halfword during the whole LOW/HIGH phase. SRAM_WE_N = 0 for counter < PHASE_CYCLES−1 and 1 on the last phase cycle, which gives data hold time.
- Read: SRAM_DQ is high-Z and SRAM_WE_N = 1. The SRAM output is sampled on the last cycle of each phase into read_data[15:0] or read_data[31:16].
- read_data holds its value until the next read. Writes never change it.
- SRAM_DQ is high-Z in IDLE, DONE, and in every read phase.
- Reset (asynchronous, at any time, including mid-write):
  - state IDLE, counter 0
  - SRAM_ADDR 0, SRAM_WE_N 1, SRAM_DQ high-Z
  - read_data 0x00000000
  - ready = 1 if no request is present
  - a partially written word is left as-is in the SRAM

## Timing
- Latency from the first cycle a request is present at IDLE to ready = 1 is 2·PHASE_CYCLES + 2 cycles (6 at default). ready is 0 for the first 2·PHASE_CYCLES + 1 of those cycles.
- The pipeline advances on the rising edge that ends the DONE cycle.
- read_data is valid in the DONE cycle, which is the cycle ready = 1.
- Back-to-back: a new request present in the cycle after DONE starts immediately. There is no dead cycle beyond the IDLE decode cycle.
- SRAM_ADDR and SRAM_WE_N change only on clock edges, so they are glitch-free.

## Test plan
- Reset and idle: assert rst = 0 mid-simulation, then release with no request → read_data 0, SRAM_WE_N 1, SRAM_DQ Z, ready stays 1 for 10 cycles.
- Single write: address 1024, data 0xDEADBEEF →
  - SRAM_ADDR 0 with DQ 0xBEEF for 2 cycles, SRAM_WE_N pattern 0,1
  - then SRAM_ADDR 1 with DQ 0xDEAD, SRAM_WE_N pattern 0,1
  - ready 0 for 5 cycles and 1 in cycle 6; SRAM model halfwords [0]=0xBEEF, [1]=0xDEAD.
- Read-back: rd_en at address 1024 after the write → SRAM_DQ is Z throughout, read_data = 0xDEADBEEF in cycle 6 with ready 1.
- Address mapping and aliasing:
  - address 1044 → SRAM_ADDR 10 then 11
  - address 1047 behaves identically
  - rd_en and wr_en both set behaves as a write, and read_data is unchanged.
- Back-to-back: a write to 1028 followed immediately by a read from 1028 → second transaction's LOW phase begins 2 cycles after the first DONE, and returns the written value.
- Reset mid-write: drop rst during the HIGH phase → SRAM_WE_N goes 1 and DQ goes Z asynchronously; after release the FSM is IDLE and the next request completes in 6 cycles.
